// File: rtl/ddr_align_pkg.sv
// Shared definitions for the DDR read-side alignment monitor: FSM encoding,
// default training word and counter sizing.
package ddr_align_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  localparam int         DATA_W_DEF     = 4;
  localparam logic [3:0] TRAIN_WORD_DEF = 4'b0011;

  // Window counters must hold the full count EVAL_CNT, not just EVAL_CNT-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ddr_align_monitor_if.sv
// Read-word / status bundle between the deserializer, the PLL phase
// controller and the alignment monitor.
interface ddr_align_monitor_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        phase;
  logic              stop;
  logic [1:0]        align_status;
  logic              status_valid;

  modport master (
    output rd_data, phase, stop,
    input  align_status, status_valid
  );

  modport slave (
    input  rd_data, phase, stop,
    output align_status, status_valid
  );
endinterface

// File: rtl/train_word_match.sv
// Combinational compare of one read word against the training word and all of
// its bit rotations.
module train_word_match #(
  parameter int                DATA_W     = 4,
  parameter logic [DATA_W-1:0] TRAIN_WORD = 4'b0011
) (
  input  logic [DATA_W-1:0] rd_data,
  output logic              is_rot,
  output logic              is_exact
);

  logic [DATA_W-1:0] rot_hit;

  // Rotation r is the word seen when the deserializer boundary is off by r bits.
  for (genvar r = 0; r < DATA_W; r++) begin : g_rot
    localparam logic [DATA_W-1:0] ROT_WORD =
      (r == 0) ? TRAIN_WORD : ((TRAIN_WORD << r) | (TRAIN_WORD >> (DATA_W - r)));
    assign rot_hit[r] = (rd_data == ROT_WORD);
  end

  assign is_rot   = |rot_hit;
  assign is_exact = rot_hit[0];

endmodule

// File: rtl/ddr_align_monitor.sv
// Training-pattern checker producing the 2-bit alignment status for the DDR
// read-clock PLL phase controller.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_STOP   | datapath stopped; counters held at 0, status held
// ST_SETTLE | discarding SETTLE_CNT words after a phase change / stop release
// ST_EVAL   | counting matching words over an EVAL_CNT-word window
module ddr_align_monitor
  import ddr_align_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(TRAIN_WORD_DEF),
  parameter int                EVAL_CNT   = 8,
  parameter int                SETTLE_CNT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr_align_monitor_if.slave    bus
);

  localparam int               CNT_W       = cnt_width(EVAL_CNT);
  localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(EVAL_CNT - 1);
  localparam logic [CNT_W-1:0] EVAL_FULL   = CNT_W'(EVAL_CNT);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CNT - 1);

  state_t           state, state_nxt;
  logic [3:0]       phase_q;
  logic [3:0]       settle_cnt, settle_nxt;
  logic [CNT_W-1:0] word_cnt, word_nxt;
  logic [CNT_W-1:0] rot_cnt, rot_nxt, rot_final;
  logic [CNT_W-1:0] exact_cnt, exact_nxt, exact_final;
  logic [1:0]       status_q, status_nxt;
  logic             valid_q, valid_nxt;
  logic             is_rot, is_exact;
  logic             phase_chg, phase_err, word_err;

  train_word_match #(
    .DATA_W     (DATA_W),
    .TRAIN_WORD (TRAIN_WORD)
  ) u_match (
    .rd_data  (bus.rd_data),
    .is_rot   (is_rot),
    .is_exact (is_exact)
  );

  assign phase_chg = (bus.phase != phase_q);

  // Window totals include the word being sampled on the closing edge.
  assign rot_final   = rot_cnt + CNT_W'(is_rot);
  assign exact_final = exact_cnt + CNT_W'(is_exact);
  assign phase_err   = (rot_final != EVAL_FULL);
  assign word_err    = phase_err | (exact_final != EVAL_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SETTLE;
      phase_q    <= 4'd0;
      settle_cnt <= 4'd0;
      word_cnt   <= '0;
      rot_cnt    <= '0;
      exact_cnt  <= '0;
      status_q   <= 2'b11;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase_q    <= bus.phase;
      settle_cnt <= settle_nxt;
      word_cnt   <= word_nxt;
      rot_cnt    <= rot_nxt;
      exact_cnt  <= exact_nxt;
      status_q   <= status_nxt;
      valid_q    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    word_nxt   = word_cnt;
    rot_nxt    = rot_cnt;
    exact_nxt  = exact_cnt;
    status_nxt = status_q;
    valid_nxt  = 1'b0;

    // Stop outranks a phase change; either one aborts a window without update.
    if (bus.stop) begin
      state_nxt  = ST_STOP;
      settle_nxt = 4'd0;
      word_nxt   = '0;
      rot_nxt    = '0;
      exact_nxt  = '0;
    end else if (phase_chg) begin
      state_nxt  = ST_SETTLE;
      settle_nxt = 4'd0;
      word_nxt   = '0;
      rot_nxt    = '0;
      exact_nxt  = '0;
    end else begin
      case (state)
        ST_STOP: begin
          state_nxt  = ST_SETTLE;
          settle_nxt = 4'd0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_nxt = 4'd0;
            state_nxt  = ST_EVAL;
          end else begin
            settle_nxt = settle_cnt + 4'd1;
          end
        end
        ST_EVAL: begin
          if (word_cnt == EVAL_LAST) begin
            status_nxt = {word_err, phase_err};
            valid_nxt  = 1'b1;
            word_nxt   = '0;
            rot_nxt    = '0;
            exact_nxt  = '0;
          end else begin
            word_nxt  = word_cnt + CNT_W'(1);
            rot_nxt   = rot_final;
            exact_nxt = exact_final;
          end
        end
        default: begin
          state_nxt  = ST_SETTLE;
          settle_nxt = 4'd0;
          word_nxt   = '0;
          rot_nxt    = '0;
          exact_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.align_status = status_q;
  assign bus.status_valid = valid_q;

endmodule

// File: tb/tb_ddr_align_monitor.sv
// Directed bench for ddr_align_monitor: expected status pulses are queued with
// their clock index as words are driven and checked when the DUT pulses.
module tb_ddr_align_monitor;

  typedef struct {
    int         cyc;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e;
  logic [1:0] exp_hold;

  ddr_align_monitor_if #(.DATA_W(4)) bus ();

  ddr_align_monitor #(
    .DATA_W     (4),
    .TRAIN_WORD (4'b0011),
    .EVAL_CNT   (8),
    .SETTLE_CNT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  // Output check at each falling edge.
  task automatic check_out();
    if (reset) return;
    if (sb.size() > 0) begin
      tests++;
      assert (sb[0].cyc >= cyc) else begin
        fails++;
        $error("FAIL missed_pulse cyc=%0d observed=none expected_at=%0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
    if (bus.status_valid) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pulse cyc=%0d observed=%b expected=no_pulse", cyc, bus.align_status);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_int("pulse_cycle", cyc, e.cyc);
        chk2("pulse_status", bus.align_status, e.st);
        exp_hold = e.st;
      end
    end else begin
      chk2("status_hold", bus.align_status, exp_hold);
    end
  endtask

  task automatic step(input logic [3:0] d);
    bus.rd_data = d;
    @(negedge clk);
    check_out();
  endtask

  // Queue an expected pulse on the edge that samples this word.
  task automatic step_exp(input logic [3:0] d, input bit pulse, input logic [1:0] st);
    exp_t x;
    if (pulse) begin
      x.cyc = cyc + 1;
      x.st  = st;
      sb.push_back(x);
    end
    step(d);
  endtask

  initial begin
    reset        = 1'b1;
    bus.rd_data  = 4'b0011;
    bus.phase    = 4'd3;
    bus.stop     = 1'b0;
    exp_hold     = 2'b11;
    repeat (2) @(negedge clk);
    chk2("reset_status", bus.align_status, 2'b11);
    chk2("reset_valid", {1'b0, bus.status_valid}, 2'b00);
    reset = 1'b0;

    // Clean pattern: phase 3 differs from reset phase_q, first pulse on clk 11.
    for (int i = 1; i <= 27; i++) step_exp(4'b0011, (i == 11) || (i == 19) || (i == 27), 2'b00);

    // Rotated word: phase fine, boundary wrong.
    for (int i = 0; i < 8; i++) step_exp(4'b0110, i == 7, 2'b10);

    // One corrupt word at index 5, then a clean window.
    for (int i = 0; i < 8; i++) step_exp((i == 5) ? 4'b0101 : 4'b0011, i == 7, 2'b11);
    for (int i = 0; i < 8; i++) step_exp(4'b0011, i == 7, 2'b00);

    // Phase change at word 6 aborts a window that would otherwise report 2'b10.
    for (int i = 0; i < 6; i++) step_exp(4'b0110, 1'b0, 2'b00);
    bus.phase = 4'd4;
    for (int i = 1; i <= 11; i++) step_exp(4'b0011, i == 11, 2'b00);

    // Stop mid-window for 20 clks; a phase change lands on the would-be window end.
    for (int i = 0; i < 3; i++) step_exp(4'b0101, 1'b0, 2'b00);
    bus.stop = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) bus.phase = 4'd5;
      step_exp(4'b0101, 1'b0, 2'b00);
    end
    bus.stop = 1'b0;
    for (int i = 1; i <= 11; i++) step_exp(4'b0110, i == 11, 2'b10);

    // Asynchronous reset right after a window-closing edge.
    for (int i = 0; i < 7; i++) step_exp(4'b0011, 1'b0, 2'b00);
    bus.rd_data = 4'b0011;
    @(posedge clk);
    #1;
    chk2("win_end_valid", {1'b0, bus.status_valid}, 2'b01);
    chk2("win_end_status", bus.align_status, 2'b00);
    reset = 1'b1;
    #1;
    chk2("async_rst_status", bus.align_status, 2'b11);
    chk2("async_rst_valid", {1'b0, bus.status_valid}, 2'b00);
    exp_hold = 2'b11;
    @(negedge clk);
    step(4'b0011);
    reset = 1'b0;
    for (int i = 1; i <= 19; i++) step_exp(4'b0011, (i == 11) || (i == 19), 2'b00);

    step(4'b0011);
    chk_int("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
